// File: rtl/pmod_keypad_entry.sv
// 4x4 matrix keypad scanner with frame-based debounce and a decimal entry
// accumulator that publishes a binary value on the E key.
module pmod_keypad_entry #(
  parameter int NDIGITS         = 2,
  parameter int NBITS           = 7,
  parameter int SCAN_POT        = 16,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       rows,
  output logic [3:0]       cols,
  output logic [3:0]       key_code,
  output logic             key_valid,
  output logic [NBITS-1:0] entry,
  output logic [1:0]       digit_count,
  output logic [NBITS-1:0] bin_out,
  output logic             bin_valid
);

  localparam int            CW         = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0] DB_TARGET  = CW'(DEBOUNCE_FRAMES);
  localparam logic [1:0]    MAX_DIGITS = 2'(NDIGITS);

  typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_t;
  typedef enum logic [1:0] {CLS_NONE, CLS_SINGLE, CLS_MULTI} cls_t;

  logic [3:0]          rows_meta;
  logic [3:0]          rows_sync;
  logic [SCAN_POT+1:0] scan_cnt;
  logic [1:0]          col_idx;
  logic                dwell_end;
  logic                frame_end;
  logic [15:0]         held_keys;
  logic [15:0]         frame_keys;
  cls_t                frame_cls;
  logic [3:0]          frame_code;
  state_t              state;
  logic [CW-1:0]       db_cnt;
  logic [3:0]          cand_code;

  function automatic logic [3:0] key_map(input logic [3:0] idx);
    case (idx)
      4'd0:    return 4'h1;
      4'd1:    return 4'h2;
      4'd2:    return 4'h3;
      4'd3:    return 4'hA;
      4'd4:    return 4'h4;
      4'd5:    return 4'h5;
      4'd6:    return 4'h6;
      4'd7:    return 4'hB;
      4'd8:    return 4'h7;
      4'd9:    return 4'h8;
      4'd10:   return 4'h9;
      4'd11:   return 4'hC;
      4'd12:   return 4'h0;
      4'd13:   return 4'hF;
      4'd14:   return 4'hE;
      default: return 4'hD;
    endcase
  endfunction

  // Upper two counter bits select the column, lower SCAN_POT bits time the dwell.
  assign col_idx   = scan_cnt[SCAN_POT+1:SCAN_POT];
  assign dwell_end = &scan_cnt[SCAN_POT-1:0];
  assign frame_end = dwell_end && (col_idx == 2'd3);
  assign cols      = ~(4'b0001 << col_idx);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rows_meta <= 4'hF;
      rows_sync <= 4'hF;
      scan_cnt  <= '0;
      held_keys <= '0;
    end else begin
      rows_meta <= rows;
      rows_sync <= rows_meta;
      scan_cnt  <= scan_cnt + (SCAN_POT+2)'(1);
      if (dwell_end) begin
        for (int r = 0; r < 4; r++) held_keys[4*r + int'(col_idx)] <= ~rows_sync[r];
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    frame_keys = held_keys;
    for (int r = 0; r < 4; r++) frame_keys[4*r + 3] = ~rows_sync[r];
  end

  always_comb begin
    frame_cls  = CLS_NONE;
    frame_code = 4'h0;
    if (frame_keys != 16'h0) begin
      if ((frame_keys & (frame_keys - 16'd1)) == 16'h0) frame_cls = CLS_SINGLE;
      else                                              frame_cls = CLS_MULTI;
    end
    for (int i = 0; i < 16; i++) begin
      if (frame_keys[i]) frame_code = key_map(4'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      db_cnt    <= '0;
      cand_code <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (frame_end) begin
        case (state)
          IDLE: begin
            if (frame_cls == CLS_SINGLE) begin
              cand_code <= frame_code;
              db_cnt    <= CW'(1);
              state     <= CONFIRM;
            end
          end
          CONFIRM: begin
            if (frame_cls == CLS_SINGLE && frame_code == cand_code) begin
              db_cnt <= db_cnt + CW'(1);
              if (db_cnt + CW'(1) == DB_TARGET) begin
                key_valid <= 1'b1;
                key_code  <= cand_code;
                state     <= HELD;
              end
            end else if (frame_cls == CLS_SINGLE) begin
              cand_code <= frame_code;
              db_cnt    <= CW'(1);
            end else begin
              state <= IDLE;
            end
          end
          HELD: begin
            if (frame_cls == CLS_NONE) begin
              db_cnt <= CW'(1);
              state  <= RELEASE;
            end
          end
          default: begin
            if (frame_cls == CLS_NONE) begin
              db_cnt <= db_cnt + CW'(1);
              if (db_cnt + CW'(1) == DB_TARGET) state <= IDLE;
            end else begin
              state <= HELD;
            end
          end
        endcase
      end
    end
  end

  // Acts on the registered key the cycle after key_valid; x10 is built from shifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry       <= '0;
      digit_count <= '0;
      bin_out     <= '0;
      bin_valid   <= 1'b0;
    end else begin
      bin_valid <= 1'b0;
      if (key_valid) begin
        if (key_code <= 4'h9) begin
          if (digit_count < MAX_DIGITS) begin
            entry       <= (entry << 3) + (entry << 1) + NBITS'(key_code);
            digit_count <= digit_count + 2'd1;
          end
        end else if (key_code == 4'hC) begin
          entry       <= '0;
          digit_count <= '0;
        end else if (key_code == 4'hE) begin
          bin_out     <= entry;
          bin_valid   <= 1'b1;
          entry       <= '0;
          digit_count <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pmod_keypad_entry.sv
// Keypad entry bench: matrix model driven by cols, table of key presses,
// scoreboard of expected key_valid events checked by a monitor.
module tb_pmod_keypad_entry;

  localparam int FRAME = 16;  // 4 columns x 2^2 dwell

  logic       clk;
  logic       rst;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic [6:0] entry;
  logic [1:0] digit_count;
  logic [6:0] bin_out;
  logic       bin_valid;
  logic [15:0] pressed;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] keys;
    int          hold;
    int          rel;
    bit          pulse;
    logic [3:0]  code;
    logic [6:0]  entry;
    logic [1:0]  dcount;
    bit          bin_en;
    logic [6:0]  bin;
  } vec_t;

  typedef struct {
    logic [3:0] code;
    logic [6:0] entry;
    logic [1:0] dcount;
    bit         bin_en;
    logic [6:0] bin;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  pmod_keypad_entry #(
    .NDIGITS(2), .NBITS(7), .SCAN_POT(2), .DEBOUNCE_FRAMES(3)
  ) dut (
    .clk(clk), .rst(rst), .rows(rows), .cols(cols),
    .key_code(key_code), .key_valid(key_valid),
    .entry(entry), .digit_count(digit_count),
    .bin_out(bin_out), .bin_valid(bin_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  function automatic logic [15:0] key_bit(input logic [3:0] code);
    logic [15:0] b;
    b = 16'h0;
    case (code)
      4'h1: b[0]  = 1'b1;
      4'h2: b[1]  = 1'b1;
      4'h3: b[2]  = 1'b1;
      4'hA: b[3]  = 1'b1;
      4'h4: b[4]  = 1'b1;
      4'h5: b[5]  = 1'b1;
      4'h6: b[6]  = 1'b1;
      4'hB: b[7]  = 1'b1;
      4'h7: b[8]  = 1'b1;
      4'h8: b[9]  = 1'b1;
      4'h9: b[10] = 1'b1;
      4'hC: b[11] = 1'b1;
      4'h0: b[12] = 1'b1;
      4'hF: b[13] = 1'b1;
      4'hE: b[14] = 1'b1;
      default: b[15] = 1'b1;
    endcase
    return b;
  endfunction

  function automatic vec_t mk(input logic [15:0] keys, input int hold, input bit pulse,
                              input logic [3:0] code, input int ent, input int dc,
                              input bit bin_en, input int bin);
    vec_t v;
    v.keys = keys; v.hold = hold; v.rel = 3; v.pulse = pulse; v.code = code;
    v.entry = 7'(ent); v.dcount = 2'(dc); v.bin_en = bin_en; v.bin = 7'(bin);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_frames(input int n);
    repeat (n * FRAME) @(negedge clk);
  endtask

  task automatic push_exp(input logic [3:0] code, input int ent, input int dc,
                          input bit bin_en, input int bin);
    exp_t e;
    e.code = code; e.entry = 7'(ent); e.dcount = 2'(dc); e.bin_en = bin_en; e.bin = 7'(bin);
    sb.push_back(e);
  endtask

  // Leaves the bench on the negedge of the first cycle of a fresh frame.
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cols"},        32'(cols),        32'hE);
    check({tag, "_key_code"},    32'(key_code),    32'h0);
    check({tag, "_key_valid"},   32'(key_valid),   32'h0);
    check({tag, "_entry"},       32'(entry),       32'h0);
    check({tag, "_digit_count"}, 32'(digit_count), 32'h0);
    check({tag, "_bin_out"},     32'(bin_out),     32'h0);
    check({tag, "_bin_valid"},   32'(bin_valid),   32'h0);
  endtask

  // Monitor: each key_valid consumes one scoreboard entry; accumulator effects are
  // checked one cycle later.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bin_valid === 1'b1) check("bin_valid_unexpected", 32'(bin_valid), 32'h0);
      if (key_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("key_valid_unexpected", 32'(key_valid), 32'h0);
        end else begin
          e = sb.pop_front();
          check("key_code", 32'(key_code), 32'(e.code));
          @(negedge clk);
          check("key_valid_width", 32'(key_valid),   32'h0);
          check("entry",           32'(entry),       32'(e.entry));
          check("digit_count",     32'(digit_count), 32'(e.dcount));
          check("bin_valid",       32'(bin_valid),   32'(e.bin_en));
          if (e.bin_en) check("bin_out", 32'(bin_out), 32'(e.bin));
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [3:0] ec;
    rst     = 1'b1;
    pressed = 16'h0;

    // key, hold frames, pulse?, code, entry, digit_count, bin?, bin_out
    vecs.push_back(mk(key_bit(4'h5), 10, 1, 4'h5,  5, 1, 0,  0));
    vecs.push_back(mk(key_bit(4'h5),  4, 1, 4'h5, 55, 2, 0,  0));
    vecs.push_back(mk(key_bit(4'hC),  4, 1, 4'hC,  0, 0, 0,  0));
    vecs.push_back(mk(key_bit(4'h4),  4, 1, 4'h4,  4, 1, 0,  0));
    vecs.push_back(mk(key_bit(4'h2),  4, 1, 4'h2, 42, 2, 0,  0));
    vecs.push_back(mk(key_bit(4'hE),  4, 1, 4'hE,  0, 0, 1, 42));
    vecs.push_back(mk(key_bit(4'h1),  4, 1, 4'h1,  1, 1, 0,  0));
    vecs.push_back(mk(key_bit(4'h2),  4, 1, 4'h2, 12, 2, 0,  0));
    vecs.push_back(mk(key_bit(4'h3),  4, 1, 4'h3, 12, 2, 0,  0));
    vecs.push_back(mk(key_bit(4'hC),  4, 1, 4'hC,  0, 0, 0,  0));
    vecs.push_back(mk(key_bit(4'hE),  4, 1, 4'hE,  0, 0, 1,  0));
    vecs.push_back(mk(key_bit(4'h9),  4, 1, 4'h9,  9, 1, 0,  0));
    vecs.push_back(mk(key_bit(4'hA),  4, 1, 4'hA,  9, 1, 0,  0));
    vecs.push_back(mk(key_bit(4'hF),  4, 1, 4'hF,  9, 1, 0,  0));
    vecs.push_back(mk(key_bit(4'hB),  4, 1, 4'hB,  9, 1, 0,  0));
    vecs.push_back(mk(key_bit(4'hD),  4, 1, 4'hD,  9, 1, 0,  0));
    vecs.push_back(mk(key_bit(4'h0),  4, 1, 4'h0, 90, 2, 0,  0));
    vecs.push_back(mk(key_bit(4'hE),  4, 1, 4'hE,  0, 0, 1, 90));
    vecs.push_back(mk(key_bit(4'h1) | key_bit(4'h6), 5, 0, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk(key_bit(4'h7),  4, 1, 4'h7,  7, 1, 0,  0));
    vecs.push_back(mk(key_bit(4'h6),  4, 1, 4'h6, 76, 2, 0,  0));
    vecs.push_back(mk(key_bit(4'hE),  4, 1, 4'hE,  0, 0, 1, 76));

    @(negedge clk);
    do_reset();
    check_reset_state("reset");

    // Column rotation: 4 cycles per pattern, back to 1110 after a full frame.
    for (int i = 0; i <= FRAME; i++) begin
      ec = 4'hF;
      ec[(i / 4) % 4] = 1'b0;
      check($sformatf("cols_cycle%0d", i), 32'(cols), 32'(ec));
      if (i < FRAME) @(negedge clk);
    end

    foreach (vecs[i]) begin
      if (vecs[i].pulse)
        push_exp(vecs[i].code, int'(vecs[i].entry), int'(vecs[i].dcount),
                 vecs[i].bin_en, int'(vecs[i].bin));
      pressed = vecs[i].keys;
      wait_frames(vecs[i].hold);
      pressed = 16'h0;
      wait_frames(vecs[i].rel);
      check($sformatf("pulse_seen_vec%0d", i), 32'(sb.size()), 32'h0);
    end

    // Bounce: 2 frames, gap, 2 frames -> nothing; third consecutive frame -> pulse.
    pressed = key_bit(4'h8);
    wait_frames(2);
    pressed = 16'h0;
    wait_frames(1);
    pressed = key_bit(4'h8);
    wait_frames(2);
    @(negedge clk);
    push_exp(4'h8, 8, 1, 0, 0);
    repeat (FRAME - 1) @(negedge clk);
    pressed = 16'h0;
    wait_frames(3);
    check("bounce_pulse_seen", 32'(sb.size()), 32'h0);

    // Reset two frames into CONFIRM with key 7 still held.
    pressed = key_bit(4'h7);
    wait_frames(2);
    do_reset();
    check_reset_state("midrst");
    wait_frames(2);
    @(negedge clk);
    push_exp(4'h7, 7, 1, 0, 0);
    repeat (FRAME - 1) @(negedge clk);
    pressed = 16'h0;
    wait_frames(3);
    check("rst_pulse_seen", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
